can_frame_sequencer: RTL

Bit-level controller for the CAN receive datapath. It follows the destuffed bit stream field by field (SOF through IFS) and drives the datapath control lines: unstuffer enable, CRC clear and enable, and packet-capture reset. It checks frame form and CRC, and hands each completed frame descriptor to the SPI inspection side through a valid/ack handshake. It sits between the unstuffer/CRC outputs and the packet-capture and SPI readout blocks.

---
 rtl/can_pkg.sv | 55 +++++
 rtl/can_field_counter.sv | 35 +++
 rtl/can_frame_sequencer.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/can_pkg.sv
// Shared definitions for the CAN receive frame sequencer.
//   field_e    : 4-bit state / field code, also exported on the debug port
//   err_e      : err_code values
//   *_BITS     : fixed field lengths loaded into the field counter
//   data_bits(): number of data bits carried by a frame given RTR and DLC
package can_pkg;

  localparam int CNT_W = 7;

  typedef enum logic [3:0] {
    ST_WAIT_IDLE = 4'd0,
    ST_IDLE      = 4'd1,
    ST_ID_A      = 4'd2,
    ST_IDE       = 4'd3,
    ST_ID_B      = 4'd4,
    ST_RES       = 4'd5,
    ST_DLC       = 4'd6,
    ST_DATA      = 4'd7,
    ST_CRC       = 4'd8,
    ST_CRC_DEL   = 4'd9,
    ST_ACK       = 4'd10,
    ST_ACK_DEL   = 4'd11,
    ST_EOF       = 4'd12,
    ST_IFS       = 4'd13
  } field_e;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_STUFF   = 3'd1,
    ERR_FORM    = 3'd2,
    ERR_CRC     = 3'd3,
    ERR_OVERRUN = 3'd4
  } err_e;

  // Base ID (11) plus RTR/SRR.
  localparam logic [CNT_W-1:0] ID_A_BITS    = 7'd12;
  // Extended ID (18) plus RTR.
  localparam logic [CNT_W-1:0] ID_B_BITS    = 7'd19;
  localparam logic [CNT_W-1:0] RES_STD_BITS = 7'd1;
  localparam logic [CNT_W-1:0] RES_EXT_BITS = 7'd2;
  localparam logic [CNT_W-1:0] DLC_BITS     = 7'd4;
  localparam logic [CNT_W-1:0] CRC_BITS     = 7'd15;

  // Remote frames carry no data; DLC codes beyond max_bytes are clamped.
  function automatic logic [CNT_W-1:0] data_bits(input logic       rtr,
                                                 input logic [3:0] dlc,
                                                 input int         max_bytes);
    int nbytes;
    if (rtr)                        nbytes = 0;
    else if (int'(dlc) > max_bytes) nbytes = max_bytes;
    else                            nbytes = int'(dlc);
    return CNT_W'(nbytes * 8);
  endfunction

endpackage

// File: rtl/can_field_counter.sv
// Down counter tracking the bits remaining in the current CAN field.
//   clk, rst_n : clock, asynchronous active-low reset (count -> RST_VAL)
//   load       : load load_val (has priority over dec)
//   load_val   : new field length
//   dec        : decrement by one, saturating at zero
//   last       : zero flag for the pending bit -- the decrement in progress
//                lands on zero, i.e. this bit is the last bit of the field
module can_field_counter
  import can_pkg::*;
#(
  parameter logic [CNT_W-1:0] RST_VAL = 7'd11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             last
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= RST_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 7'd1;
    end
  end

  assign last = (count == 7'd1);

endmodule

// File: rtl/can_frame_sequencer.sv
// Bit-level sequencer for the CAN receive datapath. Follows the destuffed
// bit stream SOF..IFS, drives unstuffer/CRC/capture control, checks form and
// CRC, and presents each good frame's descriptor to the SPI side.
//   bit_stb/bit_val/stuff_err : destuffed bit from the unstuffer (0 = dominant)
//   crc_zero                  : CRC remainder zero, sampled on CRC delimiter
//   frame_ack                 : SPI side consumed the descriptor
//   unstuff_en, crc_clr, crc_en, cap_rst : datapath controls (registered)
//   field                     : current field code (can_pkg::field_e)
//   frame_valid, ide, rtr, dlc: descriptor of the last good frame
//   frame_err, err_code       : error pulse and last error code
module can_frame_sequencer
  import can_pkg::*;
#(
  parameter int IDLE_BITS = 11,
  parameter int EOF_BITS  = 7,
  parameter int IFS_BITS  = 3,
  parameter int MAX_BYTES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bit_stb,
  input  logic       bit_val,
  input  logic       stuff_err,
  input  logic       crc_zero,
  input  logic       frame_ack,
  output logic       unstuff_en,
  output logic       crc_clr,
  output logic       crc_en,
  output logic       cap_rst,
  output logic [3:0] field,
  output logic       frame_valid,
  output logic       frame_err,
  output logic [2:0] err_code,
  output logic       ide,
  output logic       rtr,
  output logic [3:0] dlc
);

  localparam logic [CNT_W-1:0] IDLE_LEN = CNT_W'(IDLE_BITS);
  localparam logic [CNT_W-1:0] EOF_LEN  = CNT_W'(EOF_BITS);
  localparam logic [CNT_W-1:0] IFS_LEN  = CNT_W'(IFS_BITS);

  field_e           state, nxt;
  logic             cnt_load, cnt_last;
  logic [CNT_W-1:0] cnt_val, nbits;

  // Per-bit events decoded from the current state and bit.
  logic ev_err, ev_sof, ev_idle, ev_crc_done, ev_publish;
  err_e ev_code;

  // Working copy of the frame header; published only when EOF completes.
  logic       rtr_w, ide_w;
  logic [3:0] dlc_w, dlc_full;

  assign dlc_full = {dlc_w[2:0], bit_val};
  assign nbits    = data_bits(rtr_w, dlc_full, MAX_BYTES);
  assign field    = state;

  can_field_counter #(.RST_VAL(IDLE_LEN)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (bit_stb),
    .last     (cnt_last)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    nxt         = state;
    cnt_load    = 1'b0;
    cnt_val     = '0;
    ev_err      = 1'b0;
    ev_code     = ERR_NONE;
    ev_sof      = 1'b0;
    ev_idle     = 1'b0;
    ev_crc_done = 1'b0;
    ev_publish  = 1'b0;

    if (bit_stb) begin
      case (state)
        ST_WAIT_IDLE: begin
          if (!bit_val) begin
            cnt_load = 1'b1;
            cnt_val  = IDLE_LEN;
          end else if (cnt_last) begin
            nxt     = ST_IDLE;
            ev_idle = 1'b1;
          end
        end
        ST_IDLE: ev_sof = !bit_val;
        ST_ID_A: if (cnt_last) nxt = ST_IDE;
        ST_IDE: begin
          cnt_load = 1'b1;
          if (bit_val) begin
            nxt     = ST_ID_B;
            cnt_val = ID_B_BITS;
          end else begin
            nxt     = ST_RES;
            cnt_val = RES_STD_BITS;
          end
        end
        ST_ID_B: begin
          if (cnt_last) begin
            nxt      = ST_RES;
            cnt_load = 1'b1;
            cnt_val  = RES_EXT_BITS;
          end
        end
        ST_RES: begin
          if (cnt_last) begin
            nxt      = ST_DLC;
            cnt_load = 1'b1;
            cnt_val  = DLC_BITS;
          end
        end
        ST_DLC: begin
          if (cnt_last) begin
            cnt_load = 1'b1;
            if (nbits == '0) begin
              nxt     = ST_CRC;
              cnt_val = CRC_BITS;
            end else begin
              nxt     = ST_DATA;
              cnt_val = nbits;
            end
          end
        end
        ST_DATA: begin
          if (cnt_last) begin
            nxt      = ST_CRC;
            cnt_load = 1'b1;
            cnt_val  = CRC_BITS;
          end
        end
        ST_CRC: begin
          if (cnt_last) begin
            nxt         = ST_CRC_DEL;
            ev_crc_done = 1'b1;
          end
        end
        ST_CRC_DEL: begin
          if (!bit_val) begin
            ev_err  = 1'b1;
            ev_code = ERR_FORM;
          end else if (!crc_zero) begin
            ev_err  = 1'b1;
            ev_code = ERR_CRC;
          end else begin
            nxt = ST_ACK;
          end
        end
        ST_ACK: nxt = ST_ACK_DEL;
        ST_ACK_DEL: begin
          if (!bit_val) begin
            ev_err  = 1'b1;
            ev_code = ERR_FORM;
          end else begin
            nxt      = ST_EOF;
            cnt_load = 1'b1;
            cnt_val  = EOF_LEN;
          end
        end
        ST_EOF: begin
          if (!bit_val) begin
            ev_err  = 1'b1;
            ev_code = ERR_FORM;
          end else if (cnt_last) begin
            nxt        = ST_IFS;
            ev_publish = 1'b1;
            cnt_load   = 1'b1;
            cnt_val    = IFS_LEN;
          end
        end
        ST_IFS: begin
          // Without overload support a dominant bit here starts a new frame.
          if (!bit_val) begin
            ev_sof = 1'b1;
          end else if (cnt_last) begin
            nxt     = ST_IDLE;
            ev_idle = 1'b1;
          end
        end
        default: begin
          nxt      = ST_WAIT_IDLE;
          cnt_load = 1'b1;
          cnt_val  = IDLE_LEN;
        end
      endcase

      // Stuffing applies from the SOF bit through the CRC sequence.
      if (stuff_err && (ev_sof || ((state >= ST_ID_A) && (state <= ST_CRC)))) begin
        ev_err      = 1'b1;
        ev_code     = ERR_STUFF;
        ev_sof      = 1'b0;
        ev_crc_done = 1'b0;
      end

      if (ev_sof) begin
        nxt      = ST_ID_A;
        cnt_load = 1'b1;
        cnt_val  = ID_A_BITS;
      end

      if (ev_err) begin
        nxt      = ST_WAIT_IDLE;
        cnt_load = 1'b1;
        cnt_val  = IDLE_LEN;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order in the block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_WAIT_IDLE;
      unstuff_en  <= 1'b0;
      crc_clr     <= 1'b1;
      crc_en      <= 1'b0;
      cap_rst     <= 1'b1;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= ERR_NONE;
      ide         <= 1'b0;
      rtr         <= 1'b0;
      dlc         <= 4'd0;
      ide_w       <= 1'b0;
      rtr_w       <= 1'b0;
      dlc_w       <= 4'd0;
    end else begin
      state     <= nxt;
      frame_err <= 1'b0;

      if (frame_ack) frame_valid <= 1'b0;

      if (bit_stb) begin
        case (state)
          ST_ID_A: if (cnt_last) rtr_w <= bit_val;  // tentative RTR (SRR if extended)
          ST_IDE:  ide_w <= bit_val;
          ST_ID_B: if (cnt_last) rtr_w <= bit_val;  // real RTR of an extended frame
          ST_DLC:  dlc_w <= dlc_full;
          default: ;
        endcase
      end

      if (ev_idle) begin
        unstuff_en <= 1'b1;
        crc_clr    <= 1'b1;
        cap_rst    <= 1'b1;
      end

      if (ev_sof) begin
        unstuff_en <= 1'b1;
        crc_clr    <= 1'b0;
        crc_en     <= 1'b1;
        cap_rst    <= 1'b0;
      end

      if (ev_crc_done) begin
        unstuff_en <= 1'b0;
        crc_en     <= 1'b0;
      end

      // Publishing overrides a same-cycle frame_ack; an unconsumed
      // descriptor being overwritten is reported as an overrun.
      if (ev_publish) begin
        ide         <= ide_w;
        rtr         <= rtr_w;
        dlc         <= dlc_w;
        frame_valid <= 1'b1;
        if (frame_valid && !frame_ack) begin
          err_code  <= ERR_OVERRUN;
          frame_err <= 1'b1;
        end
      end

      if (ev_err) begin
        frame_err  <= 1'b1;
        err_code   <= ev_code;
        crc_clr    <= 1'b1;
        cap_rst    <= 1'b1;
        unstuff_en <= 1'b0;
        crc_en     <= 1'b0;
      end
    end
  end

endmodule
